// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int unsigned APB_ADDR_W         = 32;
  localparam int unsigned APB_DATA_W         = 32;
  localparam int unsigned APB_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts APB wait states within one ACCESS phase and flags the cycle in which
// the wait budget runs out. TIMEOUT_CYCLES = 0 disables the timeout.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] LAST = LAST_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0] MAX  = TIMEOUT_CYCLES[CNT_W-1:0];

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear on request, otherwise count wait cycles and saturate.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is flagged in the wait cycle that would bring the count to the
  // budget, so the bridge aborts after exactly TIMEOUT_CYCLES waited cycles.
  // A cycle with PREADY high never has en_i set, so completion wins.
  assign expired_o = (TIMEOUT_CYCLES != 0) && en_i && (count_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to APB3 master. One response pulse per command,
// all bus and response outputs driven straight from registers.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_t        state_q;
  logic              cmd_ready_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_error_q;
  logic              rsp_timeout_q;

  logic              timer_clr;
  logic              timer_en;
  logic              timer_expired;

  assign timer_clr = (state_q == SETUP);
  assign timer_en  = (state_q == ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expired_o(timer_expired)
  );

  // Transfer FSM; the bus registers double as the command latch.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            state_q     <= SETUP;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_write ? cmd_wdata : '0;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (PREADY) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= PSLVERR;
            rsp_rdata_q <= (!pwrite_q && !PSLVERR) ? PRDATA : '0;
          end else if (timer_expired) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b0;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge with a transaction-level
// reference model and a bench-driven APB slave.
module tb_apb_master_bridge;

  localparam int unsigned T = 16;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_acc = 0;

  apb_master_bridge #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // One command through the bridge, with the slave inserting 'waits' wait
  // states before PREADY. Expected outcome comes from the transfer rules:
  // more than T-1 waits aborts after T ACCESS cycles.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int unsigned waits, input logic err,
                      input logic [31:0] rd, input logic b2b);
    int unsigned acc;
    int unsigned exp_acc;
    int          n;
    int          acc_cyc;
    logic        got;
    logic        exp_to;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    exp_to  = (waits >= T);
    exp_acc = exp_to ? T : waits + 1;
    exp_err = exp_to | err;
    exp_rd  = (!w && !err && !exp_to) ? rd : 32'h0;
    exp_wd  = w ? d : 32'h0;

    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge PCLK);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_wait", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    acc_cyc = cyc;
    if (b2b) chk("b2b_gap", acc_cyc - last_acc, 3);
    last_acc = acc_cyc;
    chk("setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {1'b1, 1'b0, w, a, exp_wd});
    chk("rsp_idle", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, '0);

    acc = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (PSEL && PENABLE) acc++;
        chk("access_hold", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {1'b1, 1'b1, w, a, exp_wd});
        if (acc == waits + 1) begin
          PREADY = 1'b1; PSLVERR = err; PRDATA = rd;
        end else begin
          PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
        end
      end
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    chk("rsp_seen", got, 1);
    chk("access_cycles", acc, exp_acc);
    chk("latency", cyc - acc_cyc, exp_acc + 1);
    chk("rsp", {PSEL, PENABLE, cmd_ready, rsp_error, rsp_timeout, rsp_rdata},
        {1'b0, 1'b0, 1'b1, exp_err, exp_to, exp_rd});
  endtask

  initial begin
    logic        saw;
    int unsigned waits;

    // Reset state
    @(negedge PCLK);
    @(negedge PCLK);
    chk("reset_outputs",
        {PSEL, PENABLE, PWRITE, PADDR, PWDATA, cmd_ready, rsp_valid, rsp_error, rsp_timeout, rsp_rdata},
        '0);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("ready_after_rst", cmd_ready, 1);

    // Directed transfers
    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0);
    xfer(1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 3, 1'b0, 32'h1234_5678, 1'b0);
    xfer(1'b0, 32'h0000_0030, 32'h0, 1, 1'b1, 32'hAAAA_5555, 1'b0);
    xfer(1'b1, 32'h0000_0034, 32'h0BAD_F00D, 0, 1'b1, 32'h0, 1'b0);
    xfer(1'b0, 32'h0000_0040, 32'h0, 100, 1'b0, 32'h5A5A_5A5A, 1'b0);
    xfer(1'b0, 32'h0000_0044, 32'h0, T - 1, 1'b0, 32'hC0DE_0044, 1'b0);
    xfer(1'b1, 32'h0000_0048, 32'h1111_2222, T, 1'b0, 32'h0, 1'b0);

    // Back-to-back writes
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 32'h100 + 32'(i * 4), $urandom, 0, 1'b0, 32'h0, (i != 0));

    // Randomized transfers
    for (int i = 0; i < 24; i++) begin
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 3);
      xfer(1'($urandom), $urandom, $urandom, waits, ($urandom_range(0, 3) == 0), $urandom, 1'b0);
    end

    // Reset in the middle of an ACCESS phase
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h200; cmd_wdata = '0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_rst_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESET = 1'b1;
    #1 chk("rst_async", {PSEL, PENABLE, cmd_ready, rsp_valid}, '0);
    @(negedge PCLK);
    PRESET = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge PCLK);
      saw = saw | rsp_valid | PSEL;
    end
    chk("no_rsp_after_rst", saw, 0);
    chk("ready_after_mid_rst", cmd_ready, 1);
    xfer(1'b0, 32'h0000_0300, 32'h0, 2, 1'b0, 32'h8765_4321, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
